// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the architectural PC, drives the fetch handshake,
// selects next PC (sequential/branch/jump/trap/halt) and counts retired instructions.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        trap,
  output logic [31:0] mepc,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_TRAP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] redirect_target;

  // Jump outranks branch when both are presented by the retiring instruction.
  assign redirect_target = jump ? jump_target : branch_target;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mepc_d    = mepc_q;
    instret_d = instret_q;
    unique case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instret_d = instret_q + 32'd1;
          if (halt_req) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_HALTED;
          end else if (jump || branch_taken) begin
            if (redirect_target[1:0] == 2'b00) begin
              pc_d = redirect_target;
            end else begin
              // Misaligned target: remember the faulting PC and take one bubble.
              mepc_d  = pc_q;
              state_d = S_TRAP;
            end
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      S_TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = S_FETCH;
      end
      S_HALTED: if (resume) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; combinational logic above uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_VECTOR;
      mepc_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mepc_q    <= mepc_d;
      instret_q <= instret_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign mepc      = mepc_q;
  assign instret   = instret_q;
  assign imem_req  = (state_q == S_FETCH);
  assign trap      = (state_q == S_TRAP);
  assign pc_valid  = (state_q == S_FETCH) && imem_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes per-cycle expectations from a
// behavioural model; a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr;
  logic        jump = 1'b0, branch_taken = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] jump_target = '0, branch_target = '0;
  logic [31:0] pc, mepc, instret;
  logic        pc_valid, trap;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_valid(pc_valid), .trap(trap), .mepc(mepc), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        valid;
    logic        trap;
    logic [31:0] mepc;
    logic [31:0] instret;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model: mode 0=boot, 1=fetching, 2=trap bubble, 3=halted.
  int          m_mode;
  logic [31:0] m_pc, m_mepc, m_instret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RV; m_mepc = 0; m_instret = 0;
  endtask

  // Called just after a rising edge: apply inputs, record this cycle's expected outputs,
  // advance the model to what the next edge should produce, then wait for that edge.
  task automatic drive(input bit ack, input bit jmp, input logic [31:0] jt,
                       input bit br, input logic [31:0] bt, input bit hlt, input bit res);
    exp_t e;
    logic [31:0] tgt;
    imem_ack = ack; jump = jmp; jump_target = jt;
    branch_taken = br; branch_target = bt; halt_req = hlt; resume = res;
    e.pc = m_pc; e.req = (m_mode == 1); e.valid = (m_mode == 1) && ack;
    e.trap = (m_mode == 2); e.mepc = m_mepc; e.instret = m_instret;
    exp_q.push_back(e);
    case (m_mode)
      0: m_mode = 1;
      1: if (ack) begin
        m_instret = m_instret + 1;
        tgt = jmp ? jt : bt;
        if (hlt) begin
          m_pc = m_pc + 4; m_mode = 3;
        end else if (jmp || br) begin
          if (tgt % 4 == 0) m_pc = tgt;
          else begin m_mepc = m_pc; m_mode = 2; end
        end else m_pc = m_pc + 4;
      end
      2: begin m_pc = TV; m_mode = 1; end
      default: if (res) m_mode = 1;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump_to(input logic [31:0] t);
    drive(1, 1, t, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc", pc, e.pc);
      check("imem_addr", imem_addr, e.pc);
      check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      check("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
      check("trap", {31'd0, trap}, {31'd0, e.trap});
      check("mepc", mepc, e.mepc);
      check("instret", instret, e.instret);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RV);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;

    // Boot then sequential fetch with ack tied high.
    drive(1, 0, 0, 0, 0, 0, 0);
    seq(2);
    check("seq_pc8", pc, 32'h8);
    check("seq_instret2", instret, 32'd2);
    // Stall with a branch presented: everything ignored.
    repeat (3) drive(0, 0, 0, 1, 32'h40, 0, 0);
    check("stall_pc", pc, 32'h8);
    seq(2);
    check("after_stall_pc", pc, 32'h10);
    // Priority: jump over branch, then halt over both.
    drive(1, 1, 32'h80, 1, 32'h40, 0, 0);
    check("prio_jump", pc, 32'h80);
    jump_to(32'h10);
    drive(1, 1, 32'h80, 1, 32'h40, 1, 0);
    check("prio_halt", pc, 32'h14);
    drive(1, 1, 32'h200, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    // Misaligned branch from 0x20 traps to TRAP_VECTOR after one bubble.
    drive(1, 0, 0, 1, 32'h20, 0, 0);
    drive(1, 0, 0, 1, 32'h42, 0, 0);
    check("trap_mepc", mepc, 32'h20);
    check("trap_strobe", {31'd0, trap}, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("trap_vec", pc, TV);
    // Halt at 0x30 with 5 idle cycles of noise, then resume.
    jump_to(32'h30);
    drive(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++)
      drive($urandom_range(0, 1), 1, 32'h300, 1, 32'h2, 1, 0);
    check("halt_pc", pc, 32'h34);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("resume_addr", imem_addr, 32'h34);
    // Wrap at the top of the address space.
    jump_to(32'hFFFF_FFFC);
    seq(1);
    check("wrap_pc", pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jt, bt;
      jt = $urandom; bt = $urandom;
      if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, jt,
            $urandom_range(0, 4) == 0, bt, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0);
    end

    // Async reset mid-stall, between clock edges.
    jump_to(32'h44);
    drive(0, 0, 0, 0, 0, 0, 0);
    imem_ack = 1'b0;
    #7;
    imem_ack = 1'b1;
    rst = 1'b1;
    #1;
    check("async_pc", pc, RV);
    check("async_instret", instret, 32'd0);
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_valid", {31'd0, pc_valid}, 32'd0);
    check("async_mepc", mepc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    seq(3);
    check("post_rst_pc", pc, 32'hC);

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
